serial_adder_arbiter: RTL

- Shares one bit-serial 1-bit full adder datapath (sum = a^b^c, carry = majority) between two requesters.
- Round-robin arbitration picks one requester and latches its operands.
- The single full-adder slice is then sequenced LSB-first over WIDTH cycles, and the result is returned on a valid/ready response channel tagged with the requester ID.
- Sits in front of the adder datapath as its only controller; trades throughput for one adder cell.

---
 rtl/serial_adder_arbiter_if.sv | 57 +++++
 rtl/serial_adder_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/serial_adder_arbiter_if.sv
// Request/response bundle for serial_adder_arbiter.
// Optional subtract controls appear when SERIAL_ADDER_SUB_EN is defined.
//
// Handshake rule for every channel: a transfer happens on a rising clock
// edge where both valid and ready are 1. The source holds valid and its
// payload stable until that edge. The sink may raise or lower ready freely.
// The request readies are derived only from valids and controller state,
// never from rsp_ready.
interface serial_adder_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             req0_sub;
    logic             req1_sub;
`endif
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;
    logic             rsp_id;

    // Requesters and the response consumer
    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_cin,
        input  req1_ready,
`ifdef SERIAL_ADDER_SUB_EN
        output req0_sub, req1_sub,
`endif
        input  rsp_valid, rsp_sum, rsp_cout, rsp_id,
        output rsp_ready
    );

    // The shared serial adder controller
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_cin,
        output req1_ready,
`ifdef SERIAL_ADDER_SUB_EN
        input  req0_sub, req1_sub,
`endif
        output rsp_valid, rsp_sum, rsp_cout, rsp_id,
        input  rsp_ready
    );
endinterface

// File: rtl/serial_adder_arbiter.sv
// Two requesters share one bit-serial full-adder slice.
// A round-robin arbiter accepts one operand set. The slice then runs LSB-first
// for WIDTH cycles, and the registered result is returned with the owner ID.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds per-request subtract
// (B inverted, carry-in forced to 1, so rsp_cout=1 means no borrow).
module serial_adder_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    serial_adder_arbiter_if.slave   bus,
    output logic                    busy,
    output logic [1:0]              state_dbg
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   s_sr_q, s_sr_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               id_q, id_d;

    logic               grant0, grant1;
    logic               acc0, acc1;
    logic               fa_sum, fa_carry;
    logic               sub0, sub1;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub0 = bus.req0_sub;
    assign sub1 = bus.req1_sub;
`else
    assign sub0 = 1'b0;
    assign sub1 = 1'b0;
`endif

    // Round-robin grant: the requester not served last wins a tie
    always_comb begin
        grant0 = bus.req0_valid & (~bus.req1_valid | last_grant_q);
        grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
        acc0   = (state_q == IDLE) & grant0;
        acc1   = (state_q == IDLE) & grant1;
    end

    // The single shared full-adder slice
    always_comb begin
        fa_sum   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
        fa_carry = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (acc0 | acc1) state_d = CALC;
            CALC: if (cnt_q == CNT_LAST) state_d = RESP;
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; response fields come straight from registers
    always_comb begin
        bus.req0_ready = acc0;
        bus.req1_ready = acc1;
        bus.rsp_valid  = (state_q == RESP);
        bus.rsp_sum    = s_sr_q;
        bus.rsp_cout   = carry_q;
        bus.rsp_id     = id_q;
        busy           = (state_q != IDLE);
        state_dbg      = state_q;
    end

    // Datapath next values: load on accept, shift one bit per CALC cycle
    always_comb begin
        last_grant_d = last_grant_q;
        a_sr_d       = a_sr_q;
        b_sr_d       = b_sr_q;
        s_sr_d       = s_sr_q;
        carry_d      = carry_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        if (acc0) begin
            a_sr_d       = bus.req0_a;
            b_sr_d       = sub0 ? ~bus.req0_b : bus.req0_b;
            carry_d      = sub0 ? 1'b1 : bus.req0_cin;
            id_d         = 1'b0;
            last_grant_d = 1'b0;
            cnt_d        = '0;
        end else if (acc1) begin
            a_sr_d       = bus.req1_a;
            b_sr_d       = sub1 ? ~bus.req1_b : bus.req1_b;
            carry_d      = sub1 ? 1'b1 : bus.req1_cin;
            id_d         = 1'b1;
            last_grant_d = 1'b1;
            cnt_d        = '0;
        end else if (state_q == CALC) begin
            a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
            s_sr_d  = {fa_sum, s_sr_q[WIDTH-1:1]};
            carry_d = fa_carry;
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers; reset leaves req0 with first priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            s_sr_q       <= '0;
            carry_q      <= 1'b0;
            cnt_q        <= '0;
            id_q         <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            a_sr_q       <= a_sr_d;
            b_sr_q       <= b_sr_d;
            s_sr_q       <= s_sr_d;
            carry_q      <= carry_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
        end
    end
endmodule
